// File: rtl/pack_sink.sv
// Local-port packet sink: accepts flits on in_w/out_r, reassembles packets, checks dest/length, keeps stats.
// Latency: stats visible one cycle after the accepting edge; back-pressure: out_r high one cycle in STALL+1.
module pack_sink #(
    parameter int DATA_SIZE     = 8,
    parameter int ADDR_SIZE     = 4,
    parameter int ADDR          = 0,
    parameter int MAX_PACK_LEN  = 4,
    parameter int STALL         = 0,
    parameter int PACKS_TO_RECV = 16,
    parameter int CNT_W         = 16
) (
    input  logic                           clk,
    input  logic                           a_rst,
    input  logic [DATA_SIZE+ADDR_SIZE:0]   data_i,
    input  logic                           in_w,
    output logic                           out_r,
    output logic [CNT_W-1:0]               packs_cnt,
    output logic [CNT_W-1:0]               flits_cnt,
    output logic [CNT_W-1:0]               err_cnt,
    output logic                           err_flag,
    output logic                           done
);
    localparam int FLIT_SIZE = DATA_SIZE + ADDR_SIZE + 1;
    localparam int SW        = (STALL > 0) ? $clog2(STALL + 1) : 1;
    localparam int LW        = $clog2(MAX_PACK_LEN + 2);

    typedef enum logic {HEAD, BODY} state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          stall_cnt;
    logic [LW-1:0]          len_q, len_d;
    logic [ADDR_SIZE-1:0]   cur_addr_q, cur_addr_d;
    logic                   pkt_err_q;
    logic                   pkt_err_any;
    logic                   flit_err;
    logic                   complete;
    logic                   accept;
    logic                   tail;
    logic [ADDR_SIZE-1:0]   dest;
    logic [DATA_SIZE-1:0]   payload_unused;
    logic [CNT_W-1:0]       packs_next;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    assign accept         = in_w && out_r;
    assign tail           = data_i[FLIT_SIZE-1];
    assign dest           = data_i[DATA_SIZE +: ADDR_SIZE];
    assign payload_unused = data_i[DATA_SIZE-1:0];
    assign pkt_err_any    = pkt_err_q | flit_err;
    assign packs_next     = (packs_cnt == CNT_MAX) ? packs_cnt : packs_cnt + CNT_W'(1);

    // out_r is the registered image of "stall counter is zero".
    always_ff @(posedge clk) begin
        if (a_rst) begin
            stall_cnt <= '0;
            out_r     <= 1'b0;
        end else begin
            out_r     <= (stall_cnt == '0);
            stall_cnt <= (stall_cnt == SW'(STALL)) ? '0 : stall_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            state_q <= HEAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                HEAD:    state_d = tail ? HEAD : BODY;
                BODY:    state_d = tail ? HEAD : BODY;
                default: state_d = HEAD;
            endcase
        end
    end

    // Length saturates at MAX_PACK_LEN+1 so an overlong packet keeps flagging until its tail.
    always_comb begin
        flit_err   = 1'b0;
        complete   = 1'b0;
        len_d      = len_q;
        cur_addr_d = cur_addr_q;
        if (accept) begin
            complete = tail;
            case (state_q)
                HEAD: begin
                    cur_addr_d = dest;
                    len_d      = LW'(1);
                    flit_err   = (dest != ADDR_SIZE'(ADDR));
                end
                BODY: begin
                    len_d    = (len_q > LW'(MAX_PACK_LEN)) ? len_q : len_q + LW'(1);
                    flit_err = (dest != cur_addr_q) || (dest != ADDR_SIZE'(ADDR))
                               || (len_q >= LW'(MAX_PACK_LEN));
                end
                default: begin
                    flit_err = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            len_q      <= '0;
            cur_addr_q <= '0;
            pkt_err_q  <= 1'b0;
            packs_cnt  <= '0;
            flits_cnt  <= '0;
            err_cnt    <= '0;
            err_flag   <= 1'b0;
            done       <= 1'b0;
        end else begin
            len_q      <= len_d;
            cur_addr_q <= cur_addr_d;
            pkt_err_q  <= complete ? 1'b0 : pkt_err_any;
            if (accept && flits_cnt != CNT_MAX) begin
                flits_cnt <= flits_cnt + CNT_W'(1);
            end
            if (complete) begin
                packs_cnt <= packs_next;
                if (packs_next == CNT_W'(PACKS_TO_RECV)) begin
                    done <= 1'b1;
                end
                if (pkt_err_any) begin
                    err_flag <= 1'b1;
                    if (err_cnt != CNT_MAX) begin
                        err_cnt <= err_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: doc/pack_sink.md
# pack_sink

Local-port packet sink and checker for one NoC node. It sits where a node's IP block would be and terminates the switch's local output port. It accepts flits over the write/ready handshake and reassembles them into packets. It checks each packet's destination address and length, and keeps packet, flit and error statistics for the bench and for the power-gating experiments. It is the receiving end of the flit stream that the traffic generator injects.

## Interface
Parameters:
- DATA_SIZE, 8: payload bits per flit.
- ADDR_SIZE, 4: destination address bits per flit.
- ADDR, 0: this node's address; every received flit must carry it.
- MAX_PACK_LEN, 4: maximum legal packet length in flits (≥1).
- STALL, 0: back-pressure period; out_r is high one cycle in every STALL+1.
- PACKS_TO_RECV, 16: packet count that raises done.
- CNT_W, 16: width of the statistics counters.

Ports (FLIT_SIZE = DATA_SIZE+ADDR_SIZE+1):
- clk  in  1  clock, all logic on rising edge.
- a_rst  in  1  reset; one clock; reset is synchronous and active-high.
- data_i  in  FLIT_SIZE  flit from switch; [FLIT_SIZE-1] tail flag, [DATA_SIZE+:ADDR_SIZE] destination, [DATA_SIZE-1:0] payload.
- in_w  in  1  switch has a valid flit on data_i.
- out_r  out  1  sink ready to accept a flit.
- packs_cnt  out  CNT_W  completed packets.
- flits_cnt  out  CNT_W  accepted flits.
- err_cnt  out  CNT_W  packets with at least one error.
- err_flag  out  1  sticky; set on the first erroneous packet.
- done  out  1  set when packs_cnt reaches PACKS_TO_RECV; sticky.

## Operation
- Transfer: a flit is accepted on a rising edge where in_w && out_r. data_i is sampled only then. While out_r is low the switch holds data_i and in_w.
- Back-pressure: a stall counter counts 0..STALL and wraps. out_r is registered and is high exactly when the counter is 0. With STALL=0, out_r is constantly high after reset. The stall counter runs regardless of in_w. Acceptance continues after done.
- FSM HEAD/BODY, reset to HEAD:
  - HEAD, accept: latch destination into cur_addr; len=1; flag error if destination != ADDR. If the tail flag is set, complete the packet and stay in HEAD. Otherwise go to BODY.
  - BODY, accept: len+1. Flag error if destination != cur_addr or destination != ADDR. Flag error if len+1 > MAX_PACK_LEN. If the tail flag is set, complete the packet and go to HEAD.
- Length counter saturates at MAX_PACK_LEN+1, so an overlong packet stays erroneous until its tail arrives.
- Packet completion (on the tail's accepting edge):
  - packs_cnt +1.
  - If any error was flagged in the packet (including on the tail flit itself), err_cnt +1 exactly once and err_flag is set.
  - The per-packet error bit clears.
- flits_cnt +1 on every accept.
- All counters saturate at 2^CNT_W-1 and never wrap.
- done is set when packs_cnt becomes PACKS_TO_RECV and stays set until reset.
- Payload is not checked.
- Reset mid-packet discards the partial packet: FSM to HEAD, per-packet error cleared, no counter update.

## Timing
- Reset values: out_r=0, packs_cnt=0, flits_cnt=0, err_cnt=0, err_flag=0, done=0, stall counter=0, FSM=HEAD.
- First cycle after reset deasserts: out_r goes high on the first edge where a_rst is low (next-state from counter value 0).
- Counter, flag and done updates are visible one cycle after the accepting edge, i.e. registered outputs, no combinational path from inputs.
- Throughput: one flit per cycle at STALL=0; one flit per STALL+1 cycles otherwise.
- a_rst has priority over a simultaneous accept; the flit is dropped and not counted.

## Test plan
- Single-flit packets, ADDR=3, STALL=0: 5 flits with tail=1, dest=3, back-to-back -> packs_cnt=5, flits_cnt=5, err_cnt=0, out_r high every cycle.
- Multi-flit packet: 4 flits dest=3, tail on the 4th -> packs_cnt=1, flits_cnt=4, err_cnt=0; FSM returns to HEAD.
- Wrong address: 2-flit packet with dest=5 -> packs_cnt=1, err_cnt=1, err_flag=1. A following good packet leaves err_cnt=1 and err_flag=1.
- Overlong packet, MAX_PACK_LEN=4: 6 flits dest=3 -> err_cnt=1 (once, not per flit), packs_cnt=1, flits_cnt=6.
- Back-pressure with STALL=2 and in_w held high:
  - out_r pattern is 1,0,0,1,0,0…
  - 3 flits are accepted in 9 cycles.
  - data_i changes are ignored while out_r=0.
- Reset mid-packet and done:
  - Apply a_rst after 2 body flits -> all outputs 0. A following new packet is counted from len=1.
  - With PACKS_TO_RECV=2, done rises the cycle after the 2nd tail accept and stays high.
